// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-control bundle between the 5-stage core datapath and pipeline_hazard_ctrl.
// The core drives the master side; the hazard controller sits on the slave side.
interface pipeline_hazard_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic [DATA_WIDTH-1:0] ID_instruction_i;
  logic [DATA_WIDTH-1:0] EX_instruction_i;
  logic                  EX_MemRead_i;
  logic                  EX_redirect_i;
  logic                  MEM_req_i;
  logic                  MEM_ready_i;
  logic                  pc_stall_o;
  logic                  IF_ID_stall_o;
  logic                  IF_ID_flush_o;
  logic                  ID_EX_stall_o;
  logic                  ID_EX_flush_o;
  logic                  EX_MEM_stall_o;
  logic                  MEM_WB_bubble_o;
  logic                  mem_err_o;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;
  logic [CNT_WIDTH-1:0]  flush_cnt_o;

  modport master (
    output ID_instruction_i, EX_instruction_i, EX_MemRead_i, EX_redirect_i,
           MEM_req_i, MEM_ready_i,
    input  pc_stall_o, IF_ID_stall_o, IF_ID_flush_o, ID_EX_stall_o, ID_EX_flush_o,
           EX_MEM_stall_o, MEM_WB_bubble_o, mem_err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  ID_instruction_i, EX_instruction_i, EX_MemRead_i, EX_redirect_i,
           MEM_req_i, MEM_ready_i,
    output pc_stall_o, IF_ID_stall_o, IF_ID_flush_o, ID_EX_stall_o, ID_EX_flush_o,
           EX_MEM_stall_o, MEM_WB_bubble_o, mem_err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for the 5-stage core: load-use bubble, EX redirect flush, dmem wait stall + watchdog.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module pipeline_hazard_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t     state_r;
  logic [7:0] wait_cnt_r;
  logic       mem_err_r;

  logic [6:0] opcode_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic [4:0] ex_rd_s;
  logic       uses_rs1_s;
  logic       uses_rs2_s;
  logic       load_use_s;
  logic       mem_wait_s;

  logic pc_stall_s;
  logic if_id_stall_s;
  logic if_id_flush_s;
  logic id_ex_stall_s;
  logic id_ex_flush_s;
  logic ex_mem_stall_s;
  logic mem_wb_bubble_s;

  assign opcode_s = hz.ID_instruction_i[6:0];
  assign rs1_s    = hz.ID_instruction_i[19:15];
  assign rs2_s    = hz.ID_instruction_i[24:20];
  assign ex_rd_s  = hz.EX_instruction_i[11:7];

  // Operand-usage decode and hazard detection for the instruction sitting in ID
  always_comb begin
    uses_rs1_s = 1'b1;
    uses_rs2_s = 1'b0;
    case (opcode_s)
      OPC_LUI, OPC_AUIPC, OPC_JAL: uses_rs1_s = 1'b0;
      OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2_s = 1'b1;
      default: begin
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b0;
      end
    endcase
    load_use_s = hz.EX_MemRead_i && (ex_rd_s != 5'd0) &&
                 ((uses_rs1_s && (rs1_s == ex_rd_s)) || (uses_rs2_s && (rs2_s == ex_rd_s)));
    mem_wait_s = hz.MEM_req_i && !hz.MEM_ready_i;
  end

  // Prioritised stall/flush generation; mem wait freezes EX so redirect/load-use wait for its exit
  always_comb begin
    pc_stall_s      = 1'b0;
    if_id_stall_s   = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_stall_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    ex_mem_stall_s  = 1'b0;
    mem_wb_bubble_s = 1'b0;
    if (!rst_n) begin
      pc_stall_s = 1'b0;
    end else if (state_r == ST_ERR) begin
      pc_stall_s      = 1'b1;
      if_id_stall_s   = 1'b1;
      id_ex_stall_s   = 1'b1;
      ex_mem_stall_s  = 1'b1;
      mem_wb_bubble_s = 1'b1;
    end else if (mem_wait_s) begin
      pc_stall_s      = 1'b1;
      if_id_stall_s   = 1'b1;
      id_ex_stall_s   = 1'b1;
      ex_mem_stall_s  = 1'b1;
      mem_wb_bubble_s = 1'b1;
    end else if (hz.EX_redirect_i) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (load_use_s) begin
      pc_stall_s    = 1'b1;
      if_id_stall_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else begin
      pc_stall_s = 1'b0;
    end
  end

  // Dmem wait tracker with watchdog; ERR is left only through reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= 8'd0;
      mem_err_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_wait_s) begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= 8'd1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_WAIT: begin
          if (hz.MEM_ready_i || !hz.MEM_req_i) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r   <= ST_ERR;
            mem_err_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_ERR: begin
          state_r <= ST_ERR;
        end
        default: begin
          state_r    <= ST_ERR;
          mem_err_r  <= 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic [CNT_WIDTH-1:0] flush_cnt_r;

  // Saturating event counters for PC stalls and IF/ID flushes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (pc_stall_s && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (if_id_flush_s && (flush_cnt_r != '1)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign hz.stall_cnt_o = stall_cnt_r;
  assign hz.flush_cnt_o = flush_cnt_r;
`else
  assign hz.stall_cnt_o = '0;
  assign hz.flush_cnt_o = '0;
`endif

  assign hz.pc_stall_o      = pc_stall_s;
  assign hz.IF_ID_stall_o   = if_id_stall_s;
  assign hz.IF_ID_flush_o   = if_id_flush_s;
  assign hz.ID_EX_stall_o   = id_ex_stall_s;
  assign hz.ID_EX_flush_o   = id_ex_flush_s;
  assign hz.EX_MEM_stall_o  = ex_mem_stall_s;
  assign hz.MEM_WB_bubble_o = mem_wb_bubble_s;
  assign hz.mem_err_o       = mem_err_r;

endmodule
